// File: rtl/tile_buf.sv
// tile_buf: ROWS x COLS tile buffer of DW-bit elements that sits between one
// layer's compute stage and the next layer's input.
//
// A producer fills the tile with random (row, col) writes, with a streaming
// row-major push, or with both. A per-element write mask tracks which
// elements have been written. Once every element is written, the tile is
// presented on data_out with out_valid high. It is held there until the
// consumer accepts it with out_ready, or until clear discards it.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   clear              synchronous discard of the current tile
//   we/wr_row/wr_col/datain
//                      random write; ignored when the indices are out of range
//   push/push_data     streaming write at the internal row-major pointer
//   in_ready           random writes accepted (= !out_valid)
//   push_ready         push accepted (= in_ready & !we; a random write wins)
//   fill_count         number of distinct elements written in this tile
//   out_valid/out_ready
//                      tile hand-off handshake
//   data_out           flattened tile, element [0][0] in the MSBs
module tile_buf #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned DW   = 8,
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned NW  = $clog2(ROWS * COLS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      we,
  input  logic [RW-1:0]             wr_row,
  input  logic [CW-1:0]             wr_col,
  input  logic [DW-1:0]             datain,
  input  logic                      push,
  input  logic [DW-1:0]             push_data,
  output logic                      in_ready,
  output logic                      push_ready,
  output logic [NW-1:0]             fill_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROWS*COLS*DW-1:0]   data_out
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] mem_reg [N];
  logic [N-1:0]  mask_reg,  mask_next;
  logic [IW-1:0] ptr_reg,   ptr_next;
  logic [NW-1:0] count_reg, count_next;
  logic          out_valid_reg, out_valid_next;

  logic          wr_ok;
  logic          push_ok;
  logic          consume;
  logic [IW-1:0] wr_idx;

  assign in_ready   = !out_valid_reg;
  assign push_ready = in_ready & !we;
  assign fill_count = count_reg;
  assign out_valid  = out_valid_reg;

  // Out-of-range indices are dropped here. The linear index is only used
  // when wr_ok is high.
  assign wr_ok   = we & in_ready & (32'(wr_row) < ROWS) & (32'(wr_col) < COLS);
  assign wr_idx  = IW'(32'(wr_row) * COLS + 32'(wr_col));
  assign push_ok = push & push_ready;
  assign consume = out_valid_reg & out_ready;

  always_comb begin
    mask_next      = mask_reg;
    ptr_next       = ptr_reg;
    out_valid_next = out_valid_reg;
    count_next     = '0;

    if (clear || consume) begin
      mask_next      = '0;
      ptr_next       = '0;
      out_valid_next = 1'b0;
    end else if (!out_valid_reg) begin
      if (wr_ok) begin
        mask_next[wr_idx] = 1'b1;
      end else if (push_ok) begin
        mask_next[ptr_reg] = 1'b1;
        ptr_next = (32'(ptr_reg) == N - 1) ? '0 : ptr_reg + IW'(1);
      end
      // The tile becomes valid on the same edge that completes the mask.
      out_valid_next = &mask_next;
    end

    // Rewriting an element leaves the mask unchanged, so the popcount of
    // the next mask also covers the "no double counting" case.
    for (int i = 0; i < N; i++) begin
      count_next = count_next + NW'(mask_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_reg[i] <= '0;
      end
      mask_reg      <= '0;
      ptr_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      mask_reg      <= mask_next;
      ptr_reg       <= ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      // Element data is left untouched by consume and clear. Stale values
      // are simply overwritten by the next fill.
      if (!clear) begin
        if (wr_ok) begin
          mem_reg[wr_idx] <= datain;
        end else if (push_ok) begin
          mem_reg[ptr_reg] <= push_data;
        end
      end
    end
  end

  // Row-major flattening: element 0 ([0][0]) lands in the top DW bits.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_flat
      assign data_out[(N-1-gi)*DW +: DW] = mem_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_tile_buf.sv
module tb_tile_buf;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // 4x4x8 instance
  logic         a_clear, a_we, a_push, a_out_ready;
  logic [1:0]   a_wr_row, a_wr_col;
  logic [7:0]   a_datain, a_push_data;
  logic         a_in_ready, a_push_ready, a_out_valid;
  logic [4:0]   a_fill_count;
  logic [127:0] a_data_out;

  // 3x5x12 instance
  logic         b_clear, b_we, b_push, b_out_ready;
  logic [1:0]   b_wr_row;
  logic [2:0]   b_wr_col;
  logic [11:0]  b_datain, b_push_data;
  logic         b_in_ready, b_push_ready, b_out_valid;
  logic [3:0]   b_fill_count;
  logic [179:0] b_data_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] A_FULL = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [179:0] B_FULL =
    180'h100101102103104105106107108109_10A10B10C10D10E;

  tile_buf #(.ROWS(4), .COLS(4), .DW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .we(a_we),
    .wr_row(a_wr_row), .wr_col(a_wr_col), .datain(a_datain),
    .push(a_push), .push_data(a_push_data), .in_ready(a_in_ready),
    .push_ready(a_push_ready), .fill_count(a_fill_count),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out)
  );

  tile_buf #(.ROWS(3), .COLS(5), .DW(12)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .we(b_we),
    .wr_row(b_wr_row), .wr_col(b_wr_col), .datain(b_datain),
    .push(b_push), .push_data(b_push_data), .in_ready(b_in_ready),
    .push_ready(b_push_ready), .fill_count(b_fill_count),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (a_data_out !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", a_data_out); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_fill_count !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", a_fill_count); end
    checks++; if (a_in_ready !== 1'b1 || a_push_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", a_in_ready, a_push_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_stream_fill;
    for (int i = 0; i < 16; i++) begin
      a_push = 1'b1;
      a_push_data = 8'(i);
      step;
      checks++; if (a_fill_count !== 5'(i + 1)) begin failures++; $display("FAIL stream_fill_count[%0d] got=%0d exp=%0d", i, a_fill_count, i + 1); end
      checks++; if (a_out_valid !== (i == 15)) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, a_out_valid, (i == 15)); end
      $display("push %0d data=%h fill=%0d valid=%b", i, a_push_data, a_fill_count, a_out_valid);
    end
    a_push = 1'b0;
    checks++; if (a_data_out !== A_FULL) begin failures++; $display("FAIL stream_data got=%h exp=%h", a_data_out, A_FULL); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      a_out_ready = 1'b0;
      a_push = 1'b1; a_push_data = 8'hFF;
      a_we = 1'b1; a_wr_row = 2'd1; a_wr_col = 2'd1; a_datain = 8'hEE;
      step;
      checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, a_out_valid); end
      checks++; if (a_data_out !== A_FULL) begin failures++; $display("FAIL hold_data[%0d] got=%h exp=%h", i, a_data_out, A_FULL); end
      checks++; if (a_in_ready !== 1'b0 || a_push_ready !== 1'b0) begin failures++; $display("FAIL hold_ready[%0d] got=%b%b exp=00", i, a_in_ready, a_push_ready); end
      checks++; if (a_fill_count !== 5'd16) begin failures++; $display("FAIL hold_fill[%0d] got=%0d exp=16", i, a_fill_count); end
      $display("hold cycle %0d valid=%b fill=%0d", i, a_out_valid, a_fill_count);
    end
    a_we = 1'b0; a_push = 1'b0;
    a_out_ready = 1'b1;
    step;
    a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL consume_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_fill_count !== 5'd0) begin failures++; $display("FAIL consume_fill got=%0d exp=0", a_fill_count); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL consume_in_ready got=%b exp=1", a_in_ready); end
    $display("consume: valid=%b fill=%0d", a_out_valid, a_fill_count);
  endtask

  task automatic test_random_write;
    a_we = 1'b1; a_wr_row = 2'd3; a_wr_col = 2'd3; a_datain = 8'hAA;
    step;
    checks++; if (a_fill_count !== 5'd1) begin failures++; $display("FAIL rw_fill1 got=%0d exp=1", a_fill_count); end
    a_wr_row = 2'd0; a_wr_col = 2'd0; a_datain = 8'h55;
    step;
    checks++; if (a_fill_count !== 5'd2) begin failures++; $display("FAIL rw_fill2 got=%0d exp=2", a_fill_count); end
    a_datain = 8'h66;
    step;
    a_we = 1'b0;
    checks++; if (a_fill_count !== 5'd2) begin failures++; $display("FAIL rw_rewrite_fill got=%0d exp=2", a_fill_count); end
    checks++; if (a_data_out[127:120] !== 8'h66) begin failures++; $display("FAIL rw_elem00 got=%h exp=66", a_data_out[127:120]); end
    checks++; if (a_data_out[7:0] !== 8'hAA) begin failures++; $display("FAIL rw_elem33 got=%h exp=aa", a_data_out[7:0]); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rw_valid got=%b exp=0", a_out_valid); end
    $display("random writes: fill=%0d e00=%h e33=%h", a_fill_count, a_data_out[127:120], a_data_out[7:0]);
    a_clear = 1'b1;
    step;
    a_clear = 1'b0;
    checks++; if (a_fill_count !== 5'd0) begin failures++; $display("FAIL rw_clear_fill got=%0d exp=0", a_fill_count); end
  endtask

  task automatic test_we_push_collision;
    a_we = 1'b1; a_wr_row = 2'd1; a_wr_col = 2'd2; a_datain = 8'h11;
    a_push = 1'b1; a_push_data = 8'h22;
    #1;
    checks++; if (a_push_ready !== 1'b0) begin failures++; $display("FAIL coll_push_ready got=%b exp=0", a_push_ready); end
    step;
    a_we = 1'b0;
    checks++; if (a_data_out[79:72] !== 8'h11) begin failures++; $display("FAIL coll_elem12 got=%h exp=11", a_data_out[79:72]); end
    checks++; if (a_data_out[127:120] !== 8'h66) begin failures++; $display("FAIL coll_push_blocked got=%h exp=66", a_data_out[127:120]); end
    checks++; if (a_fill_count !== 5'd1) begin failures++; $display("FAIL coll_fill1 got=%0d exp=1", a_fill_count); end
    step;
    a_push_data = 8'h33;
    checks++; if (a_data_out[127:120] !== 8'h22) begin failures++; $display("FAIL coll_push_elem00 got=%h exp=22", a_data_out[127:120]); end
    checks++; if (a_fill_count !== 5'd2) begin failures++; $display("FAIL coll_fill2 got=%0d exp=2", a_fill_count); end
    step;
    a_push = 1'b0;
    checks++; if (a_data_out[119:112] !== 8'h33) begin failures++; $display("FAIL coll_push_elem01 got=%h exp=33", a_data_out[119:112]); end
    checks++; if (a_fill_count !== 5'd3) begin failures++; $display("FAIL coll_fill3 got=%0d exp=3", a_fill_count); end
    $display("collision: e12=%h e00=%h e01=%h fill=%0d", a_data_out[79:72], a_data_out[127:120], a_data_out[119:112], a_fill_count);
    a_clear = 1'b1;
    step;
    a_clear = 1'b0;
  endtask

  task automatic test_clear;
    for (int i = 0; i < 7; i++) begin
      a_push = 1'b1; a_push_data = 8'(8'h40 + i);
      step;
    end
    checks++; if (a_fill_count !== 5'd7) begin failures++; $display("FAIL clr_fill7 got=%0d exp=7", a_fill_count); end
    a_clear = 1'b1; a_push_data = 8'h77;
    step;
    a_clear = 1'b0;
    checks++; if (a_fill_count !== 5'd0) begin failures++; $display("FAIL clr_fill0 got=%0d exp=0", a_fill_count); end
    checks++; if (a_data_out[127:120] !== 8'h40) begin failures++; $display("FAIL clr_priority got=%h exp=40", a_data_out[127:120]); end
    a_push_data = 8'h99;
    step;
    a_push = 1'b0;
    checks++; if (a_data_out[127:120] !== 8'h99) begin failures++; $display("FAIL clr_next_push got=%h exp=99", a_data_out[127:120]); end
    checks++; if (a_fill_count !== 5'd1) begin failures++; $display("FAIL clr_next_fill got=%0d exp=1", a_fill_count); end
    $display("clear: e00=%h fill=%0d", a_data_out[127:120], a_fill_count);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      a_push = 1'b1; a_push_data = 8'(8'hA0 + i);
      step;
    end
    a_push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_data_out !== 128'h0) begin failures++; $display("FAIL async_data got=%h exp=0", a_data_out); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_fill_count !== 5'd0) begin failures++; $display("FAIL async_fill got=%0d exp=0", a_fill_count); end
    $display("async reset: data=%h fill=%0d", a_data_out, a_fill_count);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_odd_geometry;
    b_we = 1'b1; b_wr_row = 2'd3; b_wr_col = 3'd0; b_datain = 12'hABC;
    step;
    checks++; if (b_fill_count !== 4'd0 || b_data_out !== 180'h0) begin failures++; $display("FAIL odd_row_oob got=%0d/%h exp=0/0", b_fill_count, b_data_out); end
    b_wr_row = 2'd0; b_wr_col = 3'd5;
    step;
    checks++; if (b_fill_count !== 4'd0 || b_data_out !== 180'h0) begin failures++; $display("FAIL odd_col_oob got=%0d/%h exp=0/0", b_fill_count, b_data_out); end
    for (int k = 14; k >= 0; k--) begin
      b_wr_row = 2'(k / 5); b_wr_col = 3'(k % 5); b_datain = 12'(12'h100 + k);
      step;
      checks++; if (b_fill_count !== 4'(15 - k)) begin failures++; $display("FAIL odd_fill[%0d] got=%0d exp=%0d", k, b_fill_count, 15 - k); end
      checks++; if (b_out_valid !== (k == 0)) begin failures++; $display("FAIL odd_valid[%0d] got=%b exp=%b", k, b_out_valid, (k == 0)); end
      $display("odd write idx=%0d data=%h fill=%0d valid=%b", k, b_datain, b_fill_count, b_out_valid);
    end
    b_we = 1'b0;
    checks++; if (b_data_out !== B_FULL) begin failures++; $display("FAIL odd_data got=%h exp=%h", b_data_out, B_FULL); end
    checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL odd_in_ready got=%b exp=0", b_in_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_clear = 0; a_we = 0; a_push = 0; a_out_ready = 0;
    a_wr_row = 0; a_wr_col = 0; a_datain = 0; a_push_data = 0;
    b_clear = 0; b_we = 0; b_push = 0; b_out_ready = 0;
    b_wr_row = 0; b_wr_col = 0; b_datain = 0; b_push_data = 0;

    test_reset;
    test_stream_fill;
    test_backpressure;
    test_random_write;
    test_we_push_collision;
    test_clear;
    test_async_reset;
    test_odd_geometry;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
